// File: rtl/axi_lite_master_ctrl.sv
// Single-outstanding command/response to AXI-Lite master bridge; all outputs registered, min latency accept->rsp_valid = 3 cycles.
// Backpressure: cmd_ready only in IDLE; request VALIDs held until handshake; response wait bounded by TIMEOUT_CYCLES (0 = unbounded).
module axi_lite_master_ctrl #(
    parameter int ADDR_WIDTH     = 32,
    parameter int DATA_WIDTH     = 32,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic                  ACLK,
    input  logic                  ARESETn,
    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic                  cmd_write,
    input  logic [ADDR_WIDTH-1:0] cmd_addr,
    input  logic [DATA_WIDTH-1:0] cmd_wdata,
    output logic                  rsp_valid,
    output logic [DATA_WIDTH-1:0] rsp_data,
    output logic [1:0]            rsp_resp,
    output logic                  rsp_timeout,
    output logic [ADDR_WIDTH-1:0] AWADDR,
    output logic                  AWVALID,
    input  logic                  AWREADY,
    output logic [DATA_WIDTH-1:0] WDATA,
    output logic                  WVALID,
    input  logic                  WREADY,
    input  logic [1:0]            BRESP,
    input  logic                  BVALID,
    output logic                  BREADY,
    output logic [ADDR_WIDTH-1:0] ARDDR,
    output logic                  ARVALID,
    input  logic                  ARREADY,
    input  logic [DATA_WIDTH-1:0] RDATA,
    input  logic [1:0]            RRESP,
    input  logic                  RVALID,
    output logic                  RREADY
);

    localparam int CW      = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam int TO_LAST = (TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0;
    localparam logic [CW-1:0] TO_LAST_C   = TO_LAST[CW-1:0];
    localparam logic [1:0]    RESP_SLVERR = 2'b10;

    typedef enum logic [2:0] {IDLE, WR_REQ, WR_RESP, RD_REQ, RD_RESP, DONE} state_t;

    state_t                  state_q, state_d;
    logic [CW-1:0]           cnt_q, cnt_d;
    logic                    cmd_ready_q, cmd_ready_d;
    logic                    awvalid_q, awvalid_d, wvalid_q, wvalid_d, arvalid_q, arvalid_d;
    logic                    bready_q, bready_d, rready_q, rready_d;
    logic [ADDR_WIDTH-1:0]   awaddr_q, awaddr_d, araddr_q, araddr_d;
    logic [DATA_WIDTH-1:0]   wdata_q, wdata_d, rsp_data_q, rsp_data_d;
    logic                    rsp_valid_q, rsp_valid_d, rsp_timeout_q, rsp_timeout_d;
    logic [1:0]              rsp_resp_q, rsp_resp_d;

    logic cmd_fire, aw_done, w_done, timed_out;

    assign cmd_fire  = cmd_valid && cmd_ready_q;
    assign aw_done   = !awvalid_q || AWREADY;
    assign w_done    = !wvalid_q || WREADY;
    assign timed_out = (TIMEOUT_CYCLES != 0) && (cnt_q == TO_LAST_C);

    always_ff @(posedge ACLK or negedge ARESETn) begin
        if (!ARESETn) begin
            state_q       <= IDLE;
            cnt_q         <= '0;
            cmd_ready_q   <= 1'b0;
            awvalid_q     <= 1'b0;
            wvalid_q      <= 1'b0;
            arvalid_q     <= 1'b0;
            bready_q      <= 1'b0;
            rready_q      <= 1'b0;
            awaddr_q      <= '0;
            araddr_q      <= '0;
            wdata_q       <= '0;
            rsp_valid_q   <= 1'b0;
            rsp_data_q    <= '0;
            rsp_resp_q    <= 2'b00;
            rsp_timeout_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            cmd_ready_q   <= cmd_ready_d;
            awvalid_q     <= awvalid_d;
            wvalid_q      <= wvalid_d;
            arvalid_q     <= arvalid_d;
            bready_q      <= bready_d;
            rready_q      <= rready_d;
            awaddr_q      <= awaddr_d;
            araddr_q      <= araddr_d;
            wdata_q       <= wdata_d;
            rsp_valid_q   <= rsp_valid_d;
            rsp_data_q    <= rsp_data_d;
            rsp_resp_q    <= rsp_resp_d;
            rsp_timeout_q <= rsp_timeout_d;
        end
    end

    // A response arriving in the last counted cycle wins over the timeout.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (cmd_fire) state_d = cmd_write ? WR_REQ : RD_REQ;
            WR_REQ:  if (aw_done && w_done) state_d = WR_RESP;
            WR_RESP: if (BVALID || timed_out) state_d = DONE;
            RD_REQ:  if (ARREADY) state_d = RD_RESP;
            RD_RESP: if (RVALID || timed_out) state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        cmd_ready_d   = (state_d == IDLE);
        arvalid_d     = (state_d == RD_REQ);
        bready_d      = (state_d == WR_RESP);
        rready_d      = (state_d == RD_RESP);
        rsp_valid_d   = (state_d == DONE);
        awvalid_d     = 1'b0;
        wvalid_d      = 1'b0;
        awaddr_d      = awaddr_q;
        araddr_d      = araddr_q;
        wdata_d       = wdata_q;
        rsp_data_d    = rsp_data_q;
        rsp_resp_d    = rsp_resp_q;
        rsp_timeout_d = rsp_timeout_q;
        cnt_d         = '0;
        case (state_q)
            IDLE: begin
                if (cmd_fire && cmd_write) begin
                    awaddr_d  = cmd_addr;
                    wdata_d   = cmd_wdata;
                    awvalid_d = 1'b1;
                    wvalid_d  = 1'b1;
                end else if (cmd_fire) begin
                    araddr_d  = cmd_addr;
                end
            end
            WR_REQ: begin
                awvalid_d = awvalid_q && !AWREADY;
                wvalid_d  = wvalid_q && !WREADY;
            end
            WR_RESP: begin
                if (state_d == DONE) begin
                    rsp_data_d    = '0;
                    rsp_resp_d    = BVALID ? BRESP : RESP_SLVERR;
                    rsp_timeout_d = !BVALID;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            RD_RESP: begin
                if (state_d == DONE) begin
                    rsp_data_d    = RVALID ? RDATA : '0;
                    rsp_resp_d    = RVALID ? RRESP : RESP_SLVERR;
                    rsp_timeout_d = !RVALID;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            default: ;
        endcase
    end

    assign cmd_ready   = cmd_ready_q;
    assign AWVALID     = awvalid_q;
    assign WVALID      = wvalid_q;
    assign ARVALID     = arvalid_q;
    assign BREADY      = bready_q;
    assign RREADY      = rready_q;
    assign AWADDR      = awaddr_q;
    assign WDATA       = wdata_q;
    assign ARDDR       = araddr_q;
    assign rsp_valid   = rsp_valid_q;
    assign rsp_data    = rsp_data_q;
    assign rsp_resp    = rsp_resp_q;
    assign rsp_timeout = rsp_timeout_q;

endmodule

// File: tb/tb_axi_lite_master_ctrl.sv
// Bench for axi_lite_master_ctrl: randomized commands against a scripted AXI-Lite slave, scoreboard of expected responses.
module tb_axi_lite_master_ctrl;

    localparam int TO = 8;

    typedef struct {
        bit          wr;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] rdata;
        logic [1:0]  resp;
        int          da;
        int          dw;
        int          dr;
    } cfg_t;

    typedef struct {
        bit          wr;
        logic [31:0] data;
        logic [1:0]  resp;
        bit          to;
        int          rsp_cyc;
    } exp_t;

    logic        ACLK, ARESETn;
    logic        cmd_valid, cmd_ready, cmd_write;
    logic [31:0] cmd_addr, cmd_wdata;
    logic        rsp_valid, rsp_timeout;
    logic [31:0] rsp_data;
    logic [1:0]  rsp_resp;
    logic [31:0] AWADDR, WDATA, ARDDR, RDATA;
    logic        AWVALID, AWREADY, WVALID, WREADY, BVALID, BREADY;
    logic        ARVALID, ARREADY, RVALID, RREADY;
    logic [1:0]  BRESP, RRESP;

    cfg_t cfg_q[$];
    exp_t exp_q[$];
    int   cyc = 0;
    int   n_chk = 0, n_fail = 0;
    int   n_aw, n_w, n_ar, n_phase, n_resp;

    axi_lite_master_ctrl #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .TIMEOUT_CYCLES(TO)) dut (
        .ACLK(ACLK), .ARESETn(ARESETn),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
        .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
        .rsp_valid(rsp_valid), .rsp_data(rsp_data), .rsp_resp(rsp_resp), .rsp_timeout(rsp_timeout),
        .AWADDR(AWADDR), .AWVALID(AWVALID), .AWREADY(AWREADY),
        .WDATA(WDATA), .WVALID(WVALID), .WREADY(WREADY),
        .BRESP(BRESP), .BVALID(BVALID), .BREADY(BREADY),
        .ARDDR(ARDDR), .ARVALID(ARVALID), .ARREADY(ARREADY),
        .RDATA(RDATA), .RRESP(RRESP), .RVALID(RVALID), .RREADY(RREADY)
    );

    initial ACLK = 1'b0;
    always #5 ACLK = ~ACLK;
    always @(posedge ACLK) cyc <= cyc + 1;

    task automatic chk(input bit ok, input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (!ok) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic cfg_t rand_cfg(input bit wr);
        cfg_t c;
        c.wr    = wr;
        c.addr  = $urandom;
        c.wdata = $urandom;
        c.rdata = $urandom;
        c.resp  = 2'($urandom_range(0, 3));
        c.da    = $urandom_range(0, 4);
        c.dw    = $urandom_range(0, 4);
        c.dr    = $urandom_range(0, TO - 1);
        return c;
    endfunction

    // Reference timing: accept at N, request VALIDs at N+1, each channel waits its delay,
    // ready-for-response one cycle after the last request handshake, rsp_valid one cycle after the response.
    task automatic issue(input cfg_t c);
        exp_t e;
        int   budget, req;
        cfg_q.push_back(c);
        cmd_valid = 1'b1;
        cmd_write = c.wr;
        cmd_addr  = c.addr;
        cmd_wdata = c.wdata;
        budget    = 0;
        while (!cmd_ready && budget < 300) begin
            @(negedge ACLK);
            budget++;
        end
        chk(cmd_ready == 1'b1, "cmd_accept", cmd_ready, 1);
        if (cmd_ready) begin
            req  = c.wr ? ((c.da > c.dw) ? c.da : c.dw) : c.da;
            e.wr = c.wr;
            if (c.dr >= TO) begin
                e.to = 1'b1; e.data = 32'h0; e.resp = 2'b10;
                e.rsp_cyc = cyc + 2 + req + TO;
            end else begin
                e.to = 1'b0; e.resp = c.resp;
                e.data = c.wr ? 32'h0 : c.rdata;
                e.rsp_cyc = cyc + 3 + req + c.dr;
            end
            exp_q.push_back(e);
        end
        @(negedge ACLK);
    endtask

    task automatic wait_idle();
        int budget = 0;
        while ((exp_q.size() != 0 || !cmd_ready) && budget < 200) begin
            @(negedge ACLK);
            budget++;
        end
        chk(exp_q.size() == 0, "drain", exp_q.size(), 0);
    endtask

    task automatic do_reset();
        @(negedge ACLK);
        #2 ARESETn = 1'b0;
        #1;
        chk({cmd_ready, AWVALID, WVALID, BREADY, ARVALID, RREADY, rsp_valid, rsp_timeout, rsp_resp} == 10'h0,
            "reset_flags", {cmd_ready, AWVALID, WVALID, BREADY, ARVALID, RREADY, rsp_valid, rsp_timeout, rsp_resp}, 0);
        chk((AWADDR | WDATA | ARDDR | rsp_data) == 32'h0, "reset_buses", AWADDR | WDATA | ARDDR | rsp_data, 0);
        repeat (2) @(negedge ACLK);
        chk(rsp_valid == 1'b0, "reset_no_rsp", rsp_valid, 0);
        ARESETn = 1'b1;
        #1 chk(cmd_ready == 1'b0, "cmd_ready_at_release", cmd_ready, 0);
        @(negedge ACLK);
        chk(cmd_ready == 1'b1, "cmd_ready_after_release", cmd_ready, 1);
    endtask

    // Scripted slave: per-transaction ready/response delays come from cfg_q.
    initial begin : slave
        cfg_t cur;
        bit   busy, aw_done, w_done, ar_done, prev_rdy;
        busy = 0; aw_done = 0; w_done = 0; ar_done = 0; prev_rdy = 0;
        forever begin
            @(negedge ACLK);
            AWREADY = 0; WREADY = 0; ARREADY = 0; BVALID = 0; RVALID = 0;
            BRESP = 2'b00; RRESP = 2'b00; RDATA = 32'h0;
            if (!ARESETn) begin
                busy = 0;
                cfg_q.delete();
            end else begin
                if (!busy && (AWVALID || WVALID || ARVALID)) begin
                    chk(cfg_q.size() != 0, "slave_unexpected_req", {AWVALID, WVALID, ARVALID}, 0);
                    if (cfg_q.size() != 0) begin
                        cur = cfg_q.pop_front();
                        busy = 1; aw_done = 0; w_done = 0; ar_done = 0; prev_rdy = 0;
                        n_aw = 0; n_w = 0; n_ar = 0; n_phase = 0; n_resp = 0;
                        chk({AWVALID, WVALID, ARVALID} == (cur.wr ? 3'b110 : 3'b001), "req_kind",
                            {AWVALID, WVALID, ARVALID}, cur.wr ? 3'b110 : 3'b001);
                    end
                end
                if (busy && cur.wr) begin
                    if (!aw_done) begin
                        chk(AWVALID == 1'b1, "awvalid_held", AWVALID, 1);
                        chk(AWADDR == cur.addr, "awaddr", AWADDR, cur.addr);
                        if (cur.da == 0) begin AWREADY = 1; aw_done = 1; n_aw++; end
                        else cur.da--;
                    end else chk(AWVALID == 1'b0, "awvalid_after_hs", AWVALID, 0);
                    if (!w_done) begin
                        chk(WVALID == 1'b1, "wvalid_held", WVALID, 1);
                        chk(WDATA == cur.wdata, "wdata", WDATA, cur.wdata);
                        if (cur.dw == 0) begin WREADY = 1; w_done = 1; n_w++; end
                        else cur.dw--;
                    end else chk(WVALID == 1'b0, "wvalid_after_hs", WVALID, 0);
                    if (BREADY && !prev_rdy) n_phase++;
                    prev_rdy = BREADY;
                    if (BREADY) begin
                        if (cur.dr == 0) begin BVALID = 1; BRESP = cur.resp; n_resp++; busy = 0; end
                        else cur.dr--;
                    end
                end else if (busy) begin
                    if (!ar_done) begin
                        chk(ARVALID == 1'b1, "arvalid_held", ARVALID, 1);
                        chk(ARDDR == cur.addr, "araddr", ARDDR, cur.addr);
                        if (cur.da == 0) begin ARREADY = 1; ar_done = 1; n_ar++; end
                        else cur.da--;
                    end else chk(ARVALID == 1'b0, "arvalid_after_hs", ARVALID, 0);
                    if (RREADY && !prev_rdy) n_phase++;
                    prev_rdy = RREADY;
                    if (RREADY) begin
                        if (cur.dr == 0) begin
                            RVALID = 1; RDATA = cur.rdata; RRESP = cur.resp; n_resp++; busy = 0;
                        end else cur.dr--;
                    end
                end
            end
        end
    end

    initial begin : monitor
        exp_t        e;
        logic [31:0] last_d;
        logic [1:0]  last_r;
        logic        last_t;
        bit          prev_rsp, want_rdy;
        last_d = 0; last_r = 0; last_t = 0; prev_rsp = 0; want_rdy = 0;
        forever begin
            @(negedge ACLK);
            if (!ARESETn) begin
                exp_q.delete();
                last_d = 0; last_r = 0; last_t = 0; prev_rsp = 0; want_rdy = 0;
            end else begin
                chk(!((AWVALID || WVALID || BREADY) && (ARVALID || RREADY)), "aw_ar_overlap",
                    {AWVALID, WVALID, BREADY, ARVALID, RREADY}, 0);
                chk(!(cmd_ready && (AWVALID || WVALID || BREADY || ARVALID || RREADY || rsp_valid)),
                    "cmd_ready_exclusive", {cmd_ready, AWVALID, WVALID, BREADY, ARVALID, RREADY, rsp_valid}, 0);
                if (want_rdy) chk(cmd_ready == 1'b1, "cmd_ready_after_rsp", cmd_ready, 1);
                want_rdy = 0;
                if (rsp_valid) begin
                    chk(!prev_rsp, "rsp_pulse_width", prev_rsp, 0);
                    chk(exp_q.size() != 0, "rsp_unexpected", rsp_valid, 0);
                    if (exp_q.size() != 0) begin
                        e = exp_q.pop_front();
                        chk(rsp_data == e.data, "rsp_data", rsp_data, e.data);
                        chk(rsp_resp == e.resp, "rsp_resp", rsp_resp, e.resp);
                        chk(rsp_timeout == e.to, "rsp_timeout", rsp_timeout, e.to);
                        chk(cyc == e.rsp_cyc, "rsp_cycle", cyc, e.rsp_cyc);
                        chk({BREADY, RREADY} == 2'b00, "rdy_dropped", {BREADY, RREADY}, 0);
                        chk(n_resp == (e.to ? 0 : 1), "resp_handshakes", n_resp, e.to ? 0 : 1);
                        chk(n_phase == 1, "rdy_phases", n_phase, 1);
                        chk((e.wr ? (n_aw + n_w) : (2 * n_ar)) == 2, "req_handshakes",
                            e.wr ? (n_aw + n_w) : (2 * n_ar), 2);
                    end
                    last_d = rsp_data; last_r = rsp_resp; last_t = rsp_timeout;
                    want_rdy = 1;
                end else begin
                    chk({rsp_data, rsp_resp, rsp_timeout} == {last_d, last_r, last_t}, "rsp_hold",
                        {rsp_data, rsp_resp, rsp_timeout}, {last_d, last_r, last_t});
                end
                prev_rsp = rsp_valid;
            end
        end
    end

    initial begin : main
        cfg_t c;
        int   budget;
        ARESETn = 0; cmd_valid = 0; cmd_write = 0; cmd_addr = 0; cmd_wdata = 0;
        repeat (2) @(posedge ACLK);
        #1;
        chk({cmd_ready, AWVALID, WVALID, BREADY, ARVALID, RREADY, rsp_valid, rsp_timeout, rsp_resp} == 10'h0,
            "init_reset_flags", {cmd_ready, AWVALID, WVALID, BREADY, ARVALID, RREADY, rsp_valid, rsp_timeout, rsp_resp}, 0);
        chk((AWADDR | WDATA | ARDDR | rsp_data) == 32'h0, "init_reset_buses", AWADDR | WDATA | ARDDR | rsp_data, 0);
        @(negedge ACLK);
        ARESETn = 1;
        #1 chk(cmd_ready == 1'b0, "init_cmd_ready_at_release", cmd_ready, 0);
        @(negedge ACLK);
        chk(cmd_ready == 1'b1, "init_cmd_ready_after_release", cmd_ready, 1);

        c = rand_cfg(1);
        c.addr = 32'h0000_0010; c.wdata = 32'hDEAD_BEEF; c.resp = 2'b00; c.da = 0; c.dw = 0; c.dr = 0;
        issue(c);
        cmd_valid = 0;
        chk({AWVALID, WVALID} == 2'b11, "wr_valids_n1", {AWVALID, WVALID}, 2'b11);
        wait_idle();

        c = rand_cfg(1);
        c.da = 3; c.dw = 0; c.dr = 1;
        issue(c);
        cmd_valid = 0;
        wait_idle();

        c = rand_cfg(0);
        c.addr = 32'h0000_0020; c.rdata = 32'h1234_5678; c.resp = 2'b10; c.da = 2; c.dr = 0;
        issue(c);
        cmd_valid = 0;
        wait_idle();

        for (int i = 0; i < 6; i++) issue(rand_cfg(1'($urandom_range(0, 1))));
        cmd_valid = 0;
        wait_idle();

        for (int i = 0; i < 40; i++) begin
            issue(rand_cfg(1'($urandom_range(0, 1))));
            if ($urandom_range(0, 1) == 1) begin
                cmd_valid = 0;
                repeat ($urandom_range(0, 3)) @(negedge ACLK);
            end
        end
        cmd_valid = 0;
        wait_idle();

        c = rand_cfg(0);
        c.dr = 1000;
        issue(c);
        cmd_valid = 0;
        wait_idle();
        repeat (3) begin
            @(negedge ACLK);
            chk(RREADY == 1'b0, "no_rready_after_timeout", RREADY, 0);
        end
        do_reset();

        c = rand_cfg(1);
        c.dr = 50;
        issue(c);
        cmd_valid = 0;
        budget = 0;
        while (!BREADY && budget < 20) begin
            @(negedge ACLK);
            budget++;
        end
        chk(BREADY == 1'b1, "reach_wr_resp", BREADY, 1);
        do_reset();

        c = rand_cfg(0);
        issue(c);
        cmd_valid = 0;
        wait_idle();

        repeat (3) @(negedge ACLK);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/axi_lite_master_ctrl.md
Name:
axi_lite_master_ctrl

Overview:
- Converts a single-outstanding command/response interface into AXI-Lite master transactions on the axi_if signal set (write address, write data, write response, read address, read data channels).
- Sits between a register-access sequencer (CPU stub or config engine) and one AXI-Lite slave. It sequences each transaction, enforces AXI VALID/READY rules, and reports completion, including a response-phase timeout.

Parameters:
ADDR_WIDTH, 32, width of cmd_addr/AWADDR/ARDDR
DATA_WIDTH, 32, width of cmd_wdata/rsp_data/WDATA/RDATA
TIMEOUT_CYCLES, 1024, max cycles waiting in a response state; 0 disables timeout

Ports:
ACLK  in  1  clock, all logic on rising edge
ARESETn  in  1  asynchronous active-low reset
cmd_valid  in  1  command request
cmd_ready  out  1  controller idle, command accepted when cmd_valid&&cmd_ready
cmd_write  in  1  1=write, 0=read
cmd_addr  in  ADDR_WIDTH  transaction address
cmd_wdata  in  DATA_WIDTH  write data (ignored for reads)
rsp_valid  out  1  one-cycle completion pulse
rsp_data  out  DATA_WIDTH  read data (0 for writes/timeouts)
rsp_resp  out  2  BRESP/RRESP captured; 2'b10 on timeout
rsp_timeout  out  1  qualifies rsp_valid: response phase timed out
AWADDR  out  ADDR_WIDTH  write address
AWVALID  out  1  write address valid
AWREADY  in  1  write address ready
WDATA  out  DATA_WIDTH  write data
WVALID  out  1  write data valid
WREADY  in  1  write data ready
BRESP  in  2  write response
BVALID  in  1  write response valid
BREADY  out  1  write response ready
ARDDR  out  ADDR_WIDTH  read address
ARVALID  out  1  read address valid
ARREADY  in  1  read address ready
RDATA  in  DATA_WIDTH  read data
RRESP  in  2  read response
RVALID  in  1  read data valid
RREADY  out  1  read data ready

Behaviour:
- Reset (async, ARESETn=0): state IDLE. All outputs 0, including cmd_ready, every VALID/READY, rsp_*, AWADDR/WDATA/ARDDR. cmd_ready rises the first clock after reset release. Reset mid-transaction abandons it immediately with no rsp_valid.
- All outputs are registered. There is no combinational path from any input to any output.
- States: IDLE, WR_REQ, WR_RESP, RD_REQ, RD_RESP, DONE.
- IDLE: cmd_ready=1. On accept, latch addr/wdata. Then go to WR_REQ (AWVALID=WVALID=1 next cycle) or RD_REQ (ARVALID=1 next cycle). cmd_ready=0 in all other states.
- WR_REQ: AWVALID and WVALID drop independently on their own handshake, in any order or the same cycle. Address and data are held stable while VALID=1. A VALID is never withdrawn before its handshake. When both are done, go to WR_RESP with BREADY=1.
- WR_RESP: on BVALID, capture BRESP, BREADY=0, go to DONE.
- RD_REQ: hold ARVALID/ARDDR until ARREADY, then go to RD_RESP with RREADY=1.
- RD_RESP: on RVALID, capture RDATA/RRESP, RREADY=0, go to DONE.
- DONE: rsp_valid=1 for exactly one cycle, then IDLE. rsp_data/rsp_resp/rsp_timeout hold their values until the next rsp_valid.
- Minimum latency (slave always ready, response in same cycle): accept at cycle N, xVALID at N+1, x READY at N+2, rsp_valid at N+3, cmd_ready again at N+4.
- Timeout: a counter clears on entry to WR_RESP/RD_RESP and increments each cycle there. If it reaches TIMEOUT_CYCLES with no BVALID/RVALID:
  - drop BREADY/RREADY and go to DONE;
  - rsp_timeout=1, rsp_resp=2'b10, rsp_data=0.
  - A late response after timeout is never consumed. Recovery requires reset.
  - The request states are not timed, to keep AXI VALID-stability rules intact.
- No WSTRB: all writes are full-word. Addresses are forwarded unmodified with no alignment check.

Test Plan:
- Write 0x0000_0010 ← 0xDEAD_BEEF, slave ready at once, BRESP=00 → AWVALID/WVALID at N+1, rsp_valid at N+3 with rsp_resp=00, rsp_timeout=0.
- Write with WREADY 3 cycles ahead of AWREADY → WVALID drops after its handshake, AWVALID/AWADDR stay stable until AWREADY, then exactly one BREADY phase and one rsp_valid.
- Read 0x0000_0020, ARREADY delayed 2 cycles, RVALID with RDATA=0x1234_5678 and RRESP=10 → rsp_data=0x1234_5678, rsp_resp=10.
- TIMEOUT_CYCLES=8, read with RVALID never asserted → rsp_valid 8 cycles after RREADY rises, rsp_timeout=1, rsp_resp=10, rsp_data=0, RREADY=0.
- cmd_valid held high across back-to-back commands → second command accepted only when cmd_ready=1, with no overlap of AW/AR activity.
- ARESETn pulled low while in WR_RESP → all VALID/READY and cmd_ready are 0 asynchronously, no rsp_valid, cmd_ready=1 one cycle after release.
